// File: rtl/joy_pkg.sv
// Shared definitions for the DB15 joystick link (adapter-side transmitter and reader).
package joy_pkg;

  localparam int unsigned JOY_WIDTH = 16;
  localparam int unsigned JOY_CNT_W = 6;

  localparam int unsigned JOY_R     = 0;
  localparam int unsigned JOY_L     = 1;
  localparam int unsigned JOY_D     = 2;
  localparam int unsigned JOY_U     = 3;
  localparam int unsigned JOY_A     = 4;
  localparam int unsigned JOY_B     = 5;
  localparam int unsigned JOY_C     = 6;
  localparam int unsigned JOY_START = 7;
  localparam int unsigned JOY_X     = 8;
  localparam int unsigned JOY_Y     = 9;
  localparam int unsigned JOY_Z     = 10;
  localparam int unsigned JOY_MODE  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } joy_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with a registered rising-edge pulse.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              rise_q;

  // Idle-high reset; the edge pulse is computed one stage early so it aligns with sync_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick adapter emulation: parallel-load two player words, shift one bit per
// synchronized rising joy_clk onto an active-low serial line.
module joy_db15_tx
  import joy_pkg::*;
#(
  parameter int unsigned WIDTH       = JOY_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     joystick1,
  input  logic [WIDTH-1:0]     joystick2,
  input  logic                 joy_load,
  input  logic                 joy_clk,
  output logic                 joy_data,
  output logic                 frame_done,
  output logic [JOY_CNT_W-1:0] bit_cnt
);

  localparam int unsigned          FRAME_W   = 2 * WIDTH;
  localparam logic [JOY_CNT_W-1:0] FRAME_CNT = JOY_CNT_W'(FRAME_W);

  logic load_s;
  logic load_rise_unused;
  logic clk_level_unused;
  logic clk_rise;

  joy_state_e           state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [JOY_CNT_W-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 data_q, data_d;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk    (clk),
    .reset  (reset),
    .async_i(joy_load),
    .sync_o (load_s),
    .rise_o (load_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk    (clk),
    .reset  (reset),
    .async_i(joy_clk),
    .sync_o (clk_level_unused),
    .rise_o (clk_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      data_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  // Load level overrides everything, including a coincident clock edge.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    data_d  = ~shreg_q[0];
    if (!load_s) begin
      state_d = LOAD;
      shreg_d = {joystick2, joystick1};
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        LOAD, SHIFT: begin
          state_d = SHIFT;
          if (clk_rise) begin
            shreg_d = {1'b0, shreg_q[FRAME_W-1:1]};
            cnt_d   = cnt_q + JOY_CNT_W'(1);
            if (cnt_q == FRAME_CNT - JOY_CNT_W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        // Overrun keeps shifting zeros so the line reads released; count saturates.
        DONE: begin
          if (clk_rise) begin
            shreg_d = {1'b0, shreg_q[FRAME_W-1:1]};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign joy_data   = data_q;
  assign frame_done = done_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Scoreboard bench for joy_db15_tx: each joy_clk rise queues the expected line state,
// a monitor checks it once the synchronizer/shift latency has elapsed.
module tb_joy_db15_tx;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int HOLD = 4;

  typedef struct packed {
    logic       data;
    logic [5:0] cnt;
  } exp_t;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic [W-1:0] joystick1 = '0;
  logic [W-1:0] joystick2 = '0;
  logic         joy_load  = 1'b1;
  logic         joy_clk   = 1'b0;
  logic         joy_data;
  logic         frame_done;
  logic [5:0]   bit_cnt;

  exp_t sb_q[$];
  int   errors      = 0;
  int   checks      = 0;
  int   done_pulses = 0;

  joy_db15_tx #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .joy_load  (joy_load),
    .joy_clk   (joy_clk),
    .joy_data  (joy_data),
    .frame_done(frame_done),
    .bit_cnt   (bit_cnt)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the expected state, then issue one full joy_clk period.
  task automatic rise(input logic d, input logic [5:0] c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    sb_q.push_back(e);
    @(negedge clk);
    joy_clk = 1'b1;
    repeat (HOLD) @(negedge clk);
    joy_clk = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  // Rise k of a frame exposes bit k; beyond the frame the line is released.
  task automatic frame_rises(input logic [31:0] fr, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      if (k < 2 * W) rise(~fr[k], 6'(k));
      else           rise(1'b1, 6'(2 * W));
    end
  endtask

  task automatic load_pulse();
    @(negedge clk);
    joy_load = 1'b0;
    repeat (6) @(negedge clk);
    joy_load = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge joy_clk);
      repeat (SYNC + 2) @(posedge clk);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("joy_data", 32'(joy_data), 32'(e.data));
        chk("bit_cnt", 32'(bit_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stim
    logic [31:0] fr;

    repeat (3) @(negedge clk);
    chk("rst_joy_data", 32'(joy_data), 32'd1);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Idle: clocks without a load do nothing.
    for (int i = 0; i < 40; i++) rise(1'b1, 6'd0);
    chk("idle_done_pulses", 32'(done_pulses), 32'd0);

    // Full frame: 0x0005 / 0x8000.
    joystick1 = 16'h0005;
    joystick2 = 16'h8000;
    fr = {joystick2, joystick1};
    load_pulse();
    chk("load_bit0", 32'(joy_data), 32'd0);
    rise(1'b1, 6'd1);
    rise(1'b0, 6'd2);
    rise(1'b1, 6'd3);
    frame_rises(fr, 4, 27);
    rise(1'b0, 6'd31);
    rise(1'b1, 6'd32);
    chk("frame_done_once", 32'(done_pulses), 32'd1);
    chk("frame_bit_cnt", 32'(bit_cnt), 32'd32);

    // Mid-frame input change ignored, plus two overrun clocks.
    load_pulse();
    joystick1 = 16'hFFFF;
    frame_rises(fr, 1, 34);
    chk("overrun_done_once", 32'(done_pulses), 32'd2);
    chk("overrun_bit_cnt", 32'(bit_cnt), 32'd32);
    chk("overrun_joy_data", 32'(joy_data), 32'd1);

    // Load held low: clocks are ignored and the line shows joystick1 bit 0.
    joystick1 = 16'h0001;
    joystick2 = 16'h0000;
    @(negedge clk);
    joy_load = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) rise(1'b0, 6'd0);
    chk("hold_load_done", 32'(done_pulses), 32'd2);
    joy_load = 1'b1;
    repeat (6) @(negedge clk);
    chk("hold_release_cnt", 32'(bit_cnt), 32'd0);
    chk("hold_release_data", 32'(joy_data), 32'd0);

    // Asynchronous reset mid-frame, then a fresh load.
    joystick1 = 16'h00A5;
    joystick2 = 16'h5A00;
    fr = {joystick2, joystick1};
    load_pulse();
    frame_rises(fr, 1, 10);
    chk("pre_reset_cnt", 32'(bit_cnt), 32'd10);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_data", 32'(joy_data), 32'd1);
    chk("async_rst_cnt", 32'(bit_cnt), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rise(1'b1, 6'd0);
    rise(1'b1, 6'd0);
    load_pulse();
    chk("reload_bit0", 32'(joy_data), 32'd0);
    frame_rises(fr, 1, 16);
    chk("final_done_pulses", 32'(done_pulses), 32'd2);

    repeat (6) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
